// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter.
// Sends one command byte to an attached keyboard. It pulls the clock line low
// (inhibit), asserts the start bit (request-to-send), and shifts out data,
// parity and stop on the clock edges the device generates. It then checks the
// device ACK.
// Optional build macro: PS2_TX_AUTO_RETRY_EN. When defined, a NACK or timeout
// re-sends the frame up to two more times before tx_err is reported.
//
// Handshake: a byte is accepted on a rising clk edge where tx_valid && tx_ready.
// tx_ready is high only in IDLE and drops the cycle after acceptance.
// tx_valid seen while busy is ignored, not queued.
// Every accepted byte ends in exactly one tx_done or tx_err pulse, unless
// reset intervenes.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_drv,
  output logic       ps2_data_drv,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [2:0] state
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_SEND      = 3'd3,
    S_WAIT_ACK  = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_DONE      = 3'd6,
    S_ERR       = 3'd7
  } state_t;

  state_t           st;
  logic             clk_meta;
  logic [1:0]       clk_pair;   // {prev, cur}
  logic             data_meta;
  logic             data_cur;
  logic [9:0]       frame;      // {stop, parity, data}, shifted out LSB first
  logic [3:0]       idx;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic clk_fall;
  logic timed;
  logic tmo_hit;
  logic nack;
  logic fail;
  logic accept;
  logic can_retry;

  assign clk_fall = (clk_pair == 2'b10);
  assign timed    = (st == S_SEND) || (st == S_WAIT_ACK) || (st == S_WAIT_IDLE);
  assign tmo_hit  = timed && (tmo_cnt == TMO_LAST);
  assign nack     = (st == S_WAIT_ACK) && clk_fall && data_cur;
  assign fail     = tmo_hit || nack;
  assign accept   = (st == S_IDLE) && tx_valid && tx_ready;
  assign busy     = ~tx_ready;
  assign state    = st;

`ifdef PS2_TX_AUTO_RETRY_EN
  logic [1:0] retry_cnt;

  // Count failed attempts of the current byte; a fresh byte starts from zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retry_cnt <= 2'd0;
    end else if (accept) begin
      retry_cnt <= 2'd0;
    end else if (fail && can_retry) begin
      retry_cnt <= retry_cnt + 2'd1;
    end
  end

  assign can_retry = (retry_cnt != 2'd2);
`else
  assign can_retry = 1'b0;
`endif

  // Synchronise both open-drain lines; idle lines read high, so reset to 1
  // so that no edge appears right after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta  <= 1'b1;
      clk_pair  <= 2'b11;
      data_meta <= 1'b1;
      data_cur  <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_pair  <= {clk_pair[0], clk_meta};
      data_meta <= ps2_data;
      data_cur  <= data_meta;
    end
  end

  // Transmit sequencer with registered line drives and status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st           <= S_IDLE;
      ps2_clk_drv  <= 1'b0;
      ps2_data_drv <= 1'b0;
      tx_ready     <= 1'b1;
      tx_done      <= 1'b0;
      tx_err       <= 1'b0;
      frame        <= '0;
      idx          <= '0;
      inh_cnt      <= '0;
      tmo_cnt      <= '0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      // The timeout counter stops at its terminal value; it never wraps
      if (timed && !tmo_hit) tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (fail) begin
        ps2_data_drv <= 1'b0;
        if (can_retry) begin
          st          <= S_INHIBIT;
          ps2_clk_drv <= 1'b1;
          inh_cnt     <= '0;
          idx         <= '0;
        end else begin
          st          <= S_ERR;
          ps2_clk_drv <= 1'b0;
          tx_err      <= 1'b1;
        end
      end else begin
        case (st)
          S_IDLE: begin
            ps2_clk_drv  <= 1'b0;
            ps2_data_drv <= 1'b0;
            tx_ready     <= 1'b1;
            if (accept) begin
              frame       <= {1'b1, ~^tx_data, tx_data};
              idx         <= '0;
              inh_cnt     <= '0;
              tmo_cnt     <= '0;
              tx_ready    <= 1'b0;
              ps2_clk_drv <= 1'b1;
              st          <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_data_drv <= 1'b1;   // start bit
              st           <= S_RTS;
            end else begin
              inh_cnt <= inh_cnt + INH_W'(1);
            end
          end
          S_RTS: begin
            ps2_clk_drv <= 1'b0;      // hand the clock to the device
            tmo_cnt     <= '0;
            idx         <= '0;
            st          <= S_SEND;
          end
          S_SEND: begin
            if (clk_fall) begin
              ps2_data_drv <= ~frame[idx];
              idx          <= idx + 4'd1;
              if (idx == 4'd9) st <= S_WAIT_ACK;
            end
          end
          S_WAIT_ACK: begin
            // A high data line on this edge is a NACK and is handled as fail
            if (clk_fall) st <= S_WAIT_IDLE;
          end
          S_WAIT_IDLE: begin
            if (clk_pair[0] && data_cur) begin
              tx_done <= 1'b1;
              st      <= S_DONE;
            end
          end
          S_DONE: begin
            tx_ready <= 1'b1;
            st       <= S_IDLE;
          end
          S_ERR: begin
            tx_ready <= 1'b1;
            st       <= S_IDLE;
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: bench for ps2_tx with an open-drain PS/2 device model.
// Outcome pulses and device-captured frames are checked against expected
// queues filled when each byte is issued.
`timescale 1ns/1ps
module tb_ps2_tx;
  localparam int INH  = 100;
  localparam int TMO  = 3000;
  localparam int HALF = 40;
`ifdef PS2_TX_AUTO_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_drv;
  logic       ps2_data_drv;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic [2:0] state;

  assign ps2_clk  = ~(ps2_clk_drv | dev_clk_low);
  assign ps2_data = ~(ps2_data_drv | dev_data_low);

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_clk_drv(ps2_clk_drv), .ps2_data_drv(ps2_data_drv),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy),
    .tx_done(tx_done), .tx_err(tx_err), .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];     // expected {tx_err, tx_done} per accepted byte
  logic [9:0] frame_q[$];   // expected frame per attempt seen by the device
  int done_cnt = 0, err_cnt = 0, err_cyc = 0, rel_cyc = 0;
  int inh_run = 0, rts_run = 0, last_inh = 0, last_rts = 0, inh_phases = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outcome monitor: pops the expected outcome on every pulse
  always @(negedge clk) begin : outcome_mon
    logic [1:0] got;
    logic [1:0] e;
    if (rst && (tx_done || tx_err)) begin
      got = {tx_err, tx_done};
      if (tx_done) done_cnt++;
      if (tx_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(got), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("outcome", 32'(got), 32'(e));
      end
    end
  end

  // Line-phase monitor: lengths of inhibit and request-to-send phases
  always @(negedge clk) begin
    if (!rst) begin
      inh_run = 0;
      rts_run = 0;
    end else begin
      if (ps2_clk_drv && !ps2_data_drv) inh_run++;
      else if (inh_run != 0) begin
        last_inh = inh_run;
        inh_phases++;
        inh_run = 0;
      end
      if (ps2_clk_drv && ps2_data_drv) rts_run++;
      else if (rts_run != 0) begin
        last_rts = rts_run;
        rts_run = 0;
      end
    end
  end

  // ---------------- device model ----------------
  // mode 0: ACK, 1: NACK, 2: never clocks, 3: reset asserted during bit 4
  task automatic dev_session(input int mode);
    int n;
    logic [9:0] bits;
    logic [9:0] e;
    n = 0;
    bits = '0;
    last_inh = 0;
    last_rts = 0;
    while (!(ps2_clk_drv && ps2_data_drv) && n < INH + TMO + 1000) begin
      step();
      n++;
    end
    check("rts_seen", 32'(n < INH + TMO + 1000), 32'd1);
    if (ps2_clk_drv && ps2_data_drv) begin
      step();
      rel_cyc = cyc;
      check("clk_released", 32'(ps2_clk_drv), 32'd0);
      check("start_bit_held", 32'(ps2_data_drv), 32'd1);
      repeat (4) step();
      check("inhibit_len", 32'(last_inh), 32'(INH));
      check("rts_len", 32'(last_rts), 32'd1);
      if (mode != 2) begin
        repeat (HALF - 4) step();
        for (int i = 0; i < 10; i++) begin
          dev_clk_low = 1'b1;
          if (mode == 3 && i == 4) begin
            repeat (6) step();
            check("bit4_driven", 32'(ps2_data_drv), 32'd1);
            #1 rst = 1'b0;
            #1;
            check("rst_clk_drv", 32'(ps2_clk_drv), 32'd0);
            check("rst_data_drv", 32'(ps2_data_drv), 32'd0);
            check("rst_no_pulse", 32'({tx_done, tx_err}), 32'd0);
            dev_clk_low = 1'b0;
            return;
          end
          repeat (HALF) step();
          bits[i] = ps2_data;
          dev_clk_low = 1'b0;
          repeat (HALF) step();
        end
        if (mode == 0) dev_data_low = 1'b1;
        repeat (4) step();
        dev_clk_low = 1'b1;
        repeat (HALF) step();
        dev_clk_low = 1'b0;
        repeat (HALF) step();
        dev_data_low = 1'b0;
        check("frame_expected", 32'(frame_q.size() != 0), 32'd1);
        if (frame_q.size() != 0) begin
          e = frame_q.pop_front();
          check("frame_bits", 32'(bits), 32'(e));
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [7:0] b, input logic [1:0] outcome,
                       input logic [9:0] frame, input int nframes);
    int n;
    n = 0;
    while (!tx_ready && n < 20000) begin
      step();
      n++;
    end
    check("ready_before_issue", 32'(tx_ready), 32'd1);
    for (int k = 0; k < nframes; k++) frame_q.push_back(frame);
    exp_q.push_back(outcome);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check("ready_drops", 32'(tx_ready), 32'd0);
    check("busy_rises", 32'(busy), 32'd1);
  endtask

  task automatic wait_outcome(input int base);
    int n;
    n = 0;
    while ((done_cnt + err_cnt) == base && n < 4 * (INH + TMO)) begin
      step();
      n++;
    end
    check("outcome_in_time", 32'((done_cnt + err_cnt) != base), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bd, be, bi, n;
    repeat (3) step();
    check("reset_clk_drv", 32'(ps2_clk_drv), 32'd0);
    check("reset_data_drv", 32'(ps2_data_drv), 32'd0);
    check("reset_tx_ready", 32'(tx_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pulses", 32'({tx_done, tx_err}), 32'd0);
    check("reset_state", 32'(state), 32'd0);
    rst = 1'b1;
    repeat (3) step();

    // 0xED acknowledged: data 1,0,1,1,0,1,1,1 parity 1 stop 1
    bd = done_cnt; be = err_cnt;
    fork
      dev_session(0);
      issue(8'hED, 2'b01, 10'h3ED, 1);
    join
    wait_outcome(bd + be);
    check("ed_done_count", 32'(done_cnt - bd), 32'd1);
    check("ed_err_count", 32'(err_cnt - be), 32'd0);

    // 0xF4 acknowledged: parity 0; tx_ready returns right after tx_done
    repeat (5) step();
    fork
      dev_session(0);
      issue(8'hF4, 2'b01, 10'h2F4, 1);
    join
    n = 0;
    while (!tx_done && n < 1000) begin
      step();
      n++;
    end
    check("f4_done_seen", 32'(tx_done), 32'd1);
    check("f4_ready_during_done", 32'(tx_ready), 32'd0);
    step();
    check("f4_ready_back", 32'(tx_ready), 32'd1);
    check("f4_done_one_cycle", 32'(tx_done), 32'd0);

    // 0x00 NACKed
    repeat (5) step();
    bd = done_cnt; be = err_cnt;
    fork
      begin
        for (int k = 0; k < ATTEMPTS; k++) dev_session(1);
      end
      issue(8'h00, 2'b10, 10'h300, ATTEMPTS);
    join
    wait_outcome(bd + be);
    check("nack_done_count", 32'(done_cnt - bd), 32'd0);
    check("nack_err_count", 32'(err_cnt - be), 32'd1);
    check("nack_lines_released", 32'({ps2_clk_drv, ps2_data_drv}), 32'd0);

    // 0xFF with a silent device: timeout measured from clock release
    repeat (5) step();
    bd = done_cnt; be = err_cnt; bi = inh_phases;
    fork
      begin
        for (int k = 0; k < ATTEMPTS; k++) dev_session(2);
      end
      issue(8'hFF, 2'b10, 10'h3FF, 0);
    join
    wait_outcome(bd + be);
    check("timeout_latency", 32'(err_cyc - rel_cyc), 32'(TMO));
    check("timeout_inhibit_phases", 32'(inh_phases - bi), 32'(ATTEMPTS));
    check("timeout_err_count", 32'(err_cnt - be), 32'd1);
    check("timeout_done_count", 32'(done_cnt - bd), 32'd0);

    // Reset during SEND bit 4, then a fresh 0xF4
    repeat (5) step();
    bd = done_cnt; be = err_cnt;
    fork
      dev_session(3);
      begin
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
      end
    join
    repeat (3) step();
    check("rst_mid_state", 32'(state), 32'd0);
    check("rst_mid_ready", 32'(tx_ready), 32'd1);
    check("rst_mid_pulses", 32'((done_cnt - bd) + (err_cnt - be)), 32'd0);
    rst = 1'b1;
    repeat (3) step();
    fork
      dev_session(0);
      issue(8'hF4, 2'b01, 10'h2F4, 1);
    join
    wait_outcome(bd + be);
    check("post_rst_done_count", 32'(done_cnt - bd), 32'd1);

    // 0x55 offered while busy with 0xED is ignored
    repeat (5) step();
    bd = done_cnt; be = err_cnt; bi = inh_phases;
    fork
      dev_session(0);
      begin
        issue(8'hED, 2'b01, 10'h3ED, 1);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        repeat (300) step();
        check("busy_while_55", 32'(busy), 32'd1);
        tx_valid = 1'b0;
      end
    join
    wait_outcome(bd + be);
    repeat (200) step();
    check("busy_single_frame", 32'(inh_phases - bi), 32'd1);
    check("busy_done_count", 32'(done_cnt - bd), 32'd1);
    check("busy_idle_after", 32'(tx_ready), 32'd1);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("frame_q_drained", 32'(frame_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
